// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises the pins, deserialises 11-bit frames and
// decodes make/break/E0 sequences into the held scancode plus shift/ctrl state.
module ps2_keyboard #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int CNT_W          = 13
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       extended,
    output logic [1:0] kb_state,
    output logic       key_valid,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} dec_state_t;

    // Bit 0 is the first stage; the lines idle high so reset them to 1.
    logic [2:0] clk_sync_reg;
    logic [2:0] data_sync_reg;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            clk_sync_reg  <= 3'b111;
            data_sync_reg <= 3'b111;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[1:0], ps2_data};
        end
    end

    logic ps2_fall;
    logic data_bit;
    assign ps2_fall = clk_sync_reg[2] & ~clk_sync_reg[1];
    assign data_bit = data_sync_reg[1];

    dec_state_t       state_reg;
    logic [3:0]       bit_cnt_reg;
    logic [9:0]       shift_reg;
    logic [CNT_W-1:0] timeout_cnt_reg;

    // After ten shifts: [0] start, [8:1] data LSB first, [9] parity; stop is live.
    logic [7:0] rx_byte;
    logic       frame_ok;
    logic       ext_prefix;
    logic       is_shift;
    logic       is_ctrl;
    assign rx_byte    = shift_reg[8:1];
    assign frame_ok   = ~shift_reg[0] & data_bit & (^shift_reg[9:1]);
    assign ext_prefix = (state_reg == GOT_E0) || (state_reg == GOT_E0F0);
    assign is_shift   = ((rx_byte == 8'h12) || (rx_byte == 8'h59)) && !ext_prefix;
    assign is_ctrl    = (rx_byte == 8'h14);

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= 4'd0;
            shift_reg       <= 10'd0;
            timeout_cnt_reg <= '0;
            scancode        <= 8'h00;
            extended        <= 1'b0;
            kb_state        <= 2'b00;
            key_valid       <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (ps2_fall) begin
                timeout_cnt_reg <= '0;
                if (bit_cnt_reg == 4'd10) begin
                    bit_cnt_reg <= 4'd0;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                        state_reg <= IDLE;
                    end else if (rx_byte == 8'hE0) begin
                        state_reg <= GOT_E0;
                    end else if (rx_byte == 8'hF0) begin
                        state_reg <= ext_prefix ? GOT_E0F0 : GOT_F0;
                    end else if ((state_reg == IDLE) || (state_reg == GOT_E0)) begin
                        if (is_shift) begin
                            kb_state[0] <= 1'b1;
                        end else if (is_ctrl) begin
                            kb_state[1] <= 1'b1;
                        end else if (!(ext_prefix && rx_byte == 8'h12)) begin
                            scancode  <= rx_byte;
                            extended  <= ext_prefix;
                            key_valid <= 1'b1;
                        end
                        state_reg <= IDLE;
                    end else begin
                        if (is_shift)
                            kb_state[0] <= 1'b0;
                        if (is_ctrl)
                            kb_state[1] <= 1'b0;
                        if ((rx_byte == scancode) && (ext_prefix == extended)) begin
                            scancode <= 8'h00;
                            extended <= 1'b0;
                        end
                        state_reg <= IDLE;
                    end
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    shift_reg   <= {data_bit, shift_reg[9:1]};
                end
            end else if (bit_cnt_reg != 4'd0) begin
                // A stalled partial frame is dropped so the next start bit realigns.
                if (timeout_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_cnt_reg <= '0;
                    bit_cnt_reg     <= 4'd0;
                    frame_err       <= 1'b1;
                    state_reg       <= IDLE;
                end else begin
                    timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                end
            end else begin
                timeout_cnt_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: a byte table for decoding plus hand sequences
// for parity error, timeout and mid-frame reset.
module tb_ps2_keyboard;

    localparam int TO = 300;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       extended;
    logic [1:0] kb_state;
    logic       key_valid;
    logic       frame_err;

    ps2_keyboard #(.TIMEOUT_CYCLES(TO), .CNT_W(13)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(scancode), .extended(extended), .kb_state(kb_state),
        .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int kv_cnt = 0;
    int fe_cnt = 0;
    logic kv_prev = 1'b0;
    logic fe_prev = 1'b0;

    // Pulse counting and pulse-shape checks, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (key_valid === 1'b1) kv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if (key_valid === 1'b1 || frame_err === 1'b1) begin
            checks++;
            if ((key_valid && frame_err) || (key_valid && kv_prev) || (frame_err && fe_prev)) begin
                failures++;
                $display("FAIL pulse_shape: kv=%b fe=%b prev_kv=%b prev_fe=%b required single non-overlapping pulses",
                         key_valid, frame_err, kv_prev, fe_prev);
            end
        end
        kv_prev = (key_valid === 1'b1);
        fe_prev = (frame_err === 1'b1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Drives frame bits first..last of byte b; bad_par inverts the parity bit.
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int first, input int last);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = first; i <= last; i++) begin
            ps2_data = bits[i];
            repeat (8) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (8) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (8) @(posedge clk);
        end
        ps2_data = 1'b1;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        send_bits(b, bad_par, 0, 10);
    endtask

    typedef struct {
        logic [7:0] b;
        logic [7:0] sc;
        logic       ext;
        logic [1:0] kb;
        int         kv;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];

    initial begin
        int kv0, fe0;
        vecs = '{
            '{8'h1C, 8'h1C, 1'b0, 2'b00, 1},
            '{8'hF0, 8'h1C, 1'b0, 2'b00, 0},
            '{8'h1C, 8'h00, 1'b0, 2'b00, 0},
            '{8'h12, 8'h00, 1'b0, 2'b01, 0},
            '{8'h1C, 8'h1C, 1'b0, 2'b01, 1},
            '{8'h1C, 8'h1C, 1'b0, 2'b01, 1},
            '{8'hF0, 8'h1C, 1'b0, 2'b01, 0},
            '{8'h1C, 8'h00, 1'b0, 2'b01, 0},
            '{8'hF0, 8'h00, 1'b0, 2'b01, 0},
            '{8'h12, 8'h00, 1'b0, 2'b00, 0},
            '{8'hE0, 8'h00, 1'b0, 2'b00, 0},
            '{8'h75, 8'h75, 1'b1, 2'b00, 1},
            '{8'hE0, 8'h75, 1'b1, 2'b00, 0},
            '{8'hF0, 8'h75, 1'b1, 2'b00, 0},
            '{8'h75, 8'h00, 1'b0, 2'b00, 0},
            '{8'hE0, 8'h00, 1'b0, 2'b00, 0},
            '{8'h12, 8'h00, 1'b0, 2'b00, 0},
            '{8'h59, 8'h00, 1'b0, 2'b01, 0},
            '{8'h14, 8'h00, 1'b0, 2'b11, 0},
            '{8'h1C, 8'h1C, 1'b0, 2'b11, 1},
            '{8'hE0, 8'h1C, 1'b0, 2'b11, 0},
            '{8'hF0, 8'h1C, 1'b0, 2'b11, 0},
            '{8'h1C, 8'h1C, 1'b0, 2'b11, 0},
            '{8'hF0, 8'h1C, 1'b0, 2'b11, 0},
            '{8'h23, 8'h1C, 1'b0, 2'b11, 0},
            '{8'hE0, 8'h1C, 1'b0, 2'b11, 0},
            '{8'hF0, 8'h1C, 1'b0, 2'b11, 0},
            '{8'h14, 8'h1C, 1'b0, 2'b01, 0},
            '{8'hF0, 8'h1C, 1'b0, 2'b01, 0},
            '{8'h59, 8'h1C, 1'b0, 2'b00, 0},
            '{8'hF0, 8'h1C, 1'b0, 2'b00, 0},
            '{8'h1C, 8'h00, 1'b0, 2'b00, 0}
        };

        clrn = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_scancode", 32'(scancode), 32'h00);
        chk("reset_extended", 32'(extended), 32'h0);
        chk("reset_kb_state", 32'(kb_state), 32'h0);
        chk("reset_key_valid", 32'(key_valid), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        clrn = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            kv0 = kv_cnt;
            fe0 = fe_cnt;
            send_byte(vecs[i].b, 1'b0);
            repeat (12) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_scancode", i), 32'(scancode), 32'(vecs[i].sc));
            chk($sformatf("vec%0d_extended", i), 32'(extended), 32'(vecs[i].ext));
            chk($sformatf("vec%0d_kb_state", i), 32'(kb_state), 32'(vecs[i].kb));
            chk($sformatf("vec%0d_key_valid_pulses", i), 32'(kv_cnt - kv0), 32'(vecs[i].kv));
            chk($sformatf("vec%0d_frame_err_pulses", i), 32'(fe_cnt - fe0), 32'h0);
            $display("vec%0d byte=%02h scancode=%02h ext=%b kb=%b", i, vecs[i].b, scancode, extended, kb_state);
        end

        // Bad parity drops the byte and clears a pending E0 prefix.
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        send_byte(8'hE0, 1'b0);
        send_byte(8'h1C, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        chk("parity_frame_err", 32'(fe_cnt - fe0), 32'h1);
        chk("parity_key_valid", 32'(kv_cnt - kv0), 32'h0);
        chk("parity_scancode", 32'(scancode), 32'h00);
        send_byte(8'h75, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        chk("after_err_scancode", 32'(scancode), 32'h75);
        chk("after_err_extended", 32'(extended), 32'h0);
        send_byte(8'h32, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        chk("after_err_32", 32'(scancode), 32'h32);
        chk("after_err_kv", 32'(kv_cnt - kv0), 32'h2);
        $display("parity sequence scancode=%02h", scancode);

        // Five bits then silence: timeout discards the partial frame.
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        send_bits(8'h1C, 1'b0, 0, 4);
        repeat (TO / 2) @(posedge clk);
        #1;
        chk("timeout_not_early", 32'(fe_cnt - fe0), 32'h0);
        repeat (TO / 2 + 40) @(posedge clk);
        #1;
        chk("timeout_frame_err", 32'(fe_cnt - fe0), 32'h1);
        chk("timeout_scancode", 32'(scancode), 32'h32);
        send_byte(8'h23, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        chk("timeout_next_23", 32'(scancode), 32'h23);
        chk("timeout_kv", 32'(kv_cnt - kv0), 32'h1);
        $display("timeout sequence scancode=%02h", scancode);

        // Reset after six bits, with shift held beforehand.
        send_byte(8'h12, 1'b0);
        send_bits(8'h1C, 1'b0, 0, 5);
        @(posedge clk);
        #1 clrn = 1'b0;
        @(posedge clk);
        #1 clrn = 1'b1;
        chk("midreset_scancode", 32'(scancode), 32'h00);
        chk("midreset_kb_state", 32'(kb_state), 32'h0);
        chk("midreset_extended", 32'(extended), 32'h0);
        kv0 = kv_cnt;
        send_bits(8'h1C, 1'b0, 6, 10);
        repeat (12) @(posedge clk);
        #1;
        chk("midreset_tail_kv", 32'(kv_cnt - kv0), 32'h0);
        chk("midreset_tail_scancode", 32'(scancode), 32'h00);
        repeat (TO + 40) @(posedge clk);
        send_byte(8'h1C, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        chk("midreset_next_1C", 32'(scancode), 32'h1C);
        chk("midreset_next_kv", 32'(kv_cnt - kv0), 32'h1);
        $display("reset sequence scancode=%02h", scancode);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
